// File: rtl/fb_rect_filler.sv
// Rectangle-fill engine feeding the framebuffer write port: clips a command to the screen and
// emits one pixel per clock in row-major order. First write 2 cycles after accept; ready only when idle/FIN.
module fb_rect_filler #(
  parameter int FB_WIDTH      = 160,
  parameter int FB_HEIGHT     = 120,
  parameter int FB_COLOR_BITS = 9
) (
  input  logic                     Fast_Clock,
  input  logic                     Reset,
  input  logic                     Cmd_Valid,
  output logic                     Cmd_Ready,
  input  logic signed [31:0]       Cmd_X0,
  input  logic signed [31:0]       Cmd_Y0,
  input  logic signed [31:0]       Cmd_X1,
  input  logic signed [31:0]       Cmd_Y1,
  input  logic [FB_COLOR_BITS-1:0] Cmd_Color,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Enable_Draw,
  output logic [31:0]              Draw_X,
  output logic [31:0]              Draw_Y,
  output logic [31:0]              Draw_Color
);

  localparam int XW = $clog2(FB_WIDTH);
  localparam int YW = $clog2(FB_HEIGHT);
  localparam logic signed [31:0] X_MAX = 32'(FB_WIDTH - 1);
  localparam logic signed [31:0] Y_MAX = 32'(FB_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_FIN} state_t;

  state_t                   r_state, w_state_nxt;
  logic signed [31:0]       r_x0, r_y0, r_x1, r_y1;
  logic [FB_COLOR_BITS-1:0] r_color;
  logic [XW-1:0]            r_xl, r_xh, r_x;
  logic [YW-1:0]            r_yh, r_y;
  logic                     r_ready, r_busy, r_done, r_en;

  logic [XW-1:0]            w_xl_nxt, w_xh_nxt, w_x_nxt;
  logic [YW-1:0]            w_yh_nxt, w_y_nxt;
  logic                     w_ready_nxt, w_busy_nxt, w_done_nxt, w_en_nxt, w_latch;

  // Normalise corner order, then clip against the screen with signed compares.
  logic signed [31:0] w_xmin, w_xmax, w_ymin, w_ymax;
  logic signed [31:0] w_xl, w_xh, w_yl, w_yh;
  logic               w_offscreen;

  always_comb begin
    w_xmin      = (r_x0 < r_x1) ? r_x0 : r_x1;
    w_xmax      = (r_x0 < r_x1) ? r_x1 : r_x0;
    w_ymin      = (r_y0 < r_y1) ? r_y0 : r_y1;
    w_ymax      = (r_y0 < r_y1) ? r_y1 : r_y0;
    w_xl        = (w_xmin < 32'sd0) ? 32'sd0 : w_xmin;
    w_xh        = (w_xmax > X_MAX) ? X_MAX : w_xmax;
    w_yl        = (w_ymin < 32'sd0) ? 32'sd0 : w_ymin;
    w_yh        = (w_ymax > Y_MAX) ? Y_MAX : w_ymax;
    w_offscreen = (w_xl > w_xh) || (w_yl > w_yh);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready_nxt = r_ready;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_en_nxt    = r_en;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_xl_nxt    = r_xl;
    w_xh_nxt    = r_xh;
    w_yh_nxt    = r_yh;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE, S_FIN: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        if (Cmd_Valid && r_ready) begin
          w_latch     = 1'b1;
          w_state_nxt = S_SETUP;
          w_ready_nxt = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_SETUP: begin
        if (w_offscreen) begin
          w_state_nxt = S_FIN;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_ready_nxt = 1'b1;
        end else begin
          w_state_nxt = S_FILL;
          w_xl_nxt    = w_xl[XW-1:0];
          w_xh_nxt    = w_xh[XW-1:0];
          w_yh_nxt    = w_yh[YW-1:0];
          w_x_nxt     = w_xl[XW-1:0];
          w_y_nxt     = w_yl[YW-1:0];
          w_en_nxt    = 1'b1;
        end
      end
      S_FILL: begin
        if ((r_x == r_xh) && (r_y == r_yh)) begin
          w_state_nxt = S_FIN;
          w_en_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_ready_nxt = 1'b1;
        end else if (r_x < r_xh) begin
          w_x_nxt = r_x + 1'b1;
        end else begin
          w_x_nxt = r_xl;
          w_y_nxt = r_y + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Fast_Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_en    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_xl    <= '0;
      r_xh    <= '0;
      r_yh    <= '0;
      r_x0    <= '0;
      r_y0    <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
      r_color <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_en    <= w_en_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_xl    <= w_xl_nxt;
      r_xh    <= w_xh_nxt;
      r_yh    <= w_yh_nxt;
      if (w_latch) begin
        r_x0    <= Cmd_X0;
        r_y0    <= Cmd_Y0;
        r_x1    <= Cmd_X1;
        r_y1    <= Cmd_Y1;
        r_color <= Cmd_Color;
      end
    end
  end

  assign Cmd_Ready   = r_ready;
  assign Busy        = r_busy;
  assign Done        = r_done;
  assign Enable_Draw = r_en;
  assign Draw_X      = {{(32-XW){1'b0}}, r_x};
  assign Draw_Y      = {{(32-YW){1'b0}}, r_y};
  assign Draw_Color  = {{(32-FB_COLOR_BITS){1'b0}}, r_color};

endmodule

// File: tb/tb_fb_rect_filler.sv
// Randomised and directed checks of fb_rect_filler against a clip-and-scan reference model.
module tb_fb_rect_filler;

  logic               Fast_Clock = 1'b0;
  logic               Reset;
  logic               Cmd_Valid;
  logic               Cmd_Ready;
  logic signed [31:0] Cmd_X0, Cmd_Y0, Cmd_X1, Cmd_Y1;
  logic [8:0]         Cmd_Color;
  logic               Busy, Done, Enable_Draw;
  logic [31:0]        Draw_X, Draw_Y, Draw_Color;

  int total = 0;
  int bad   = 0;
  int ex_q[$];
  int ey_q[$];
  logic [8:0] cur_col;

  always #5 Fast_Clock = ~Fast_Clock;

  fb_rect_filler dut (
    .Fast_Clock (Fast_Clock),
    .Reset      (Reset),
    .Cmd_Valid  (Cmd_Valid),
    .Cmd_Ready  (Cmd_Ready),
    .Cmd_X0     (Cmd_X0),
    .Cmd_Y0     (Cmd_Y0),
    .Cmd_X1     (Cmd_X1),
    .Cmd_Y1     (Cmd_Y1),
    .Cmd_Color  (Cmd_Color),
    .Busy       (Busy),
    .Done       (Done),
    .Enable_Draw(Enable_Draw),
    .Draw_X     (Draw_X),
    .Draw_Y     (Draw_Y),
    .Draw_Color (Draw_Color)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {Enable_Draw, Done, Cmd_Ready, Busy};
  endfunction

  task automatic tick();
    @(posedge Fast_Clock);
    #1;
  endtask

  // Reference: expected pixel list from clipped bounds, scanned row by row.
  task automatic build_exp(input int x0, input int y0, input int x1, input int y1);
    int xl, xh, yl, yh;
    ex_q.delete();
    ey_q.delete();
    xl = (x0 < x1) ? x0 : x1;  xh = (x0 < x1) ? x1 : x0;
    yl = (y0 < y1) ? y0 : y1;  yh = (y0 < y1) ? y1 : y0;
    if (xl < 0) xl = 0;
    if (yl < 0) yl = 0;
    if (xh > 159) xh = 159;
    if (yh > 119) yh = 119;
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++) begin
        ex_q.push_back(x);
        ey_q.push_back(y);
      end
  endtask

  task automatic noise();
    Cmd_Valid = 1'($urandom);
    Cmd_X0 = $urandom; Cmd_Y0 = $urandom; Cmd_X1 = $urandom; Cmd_Y1 = $urandom;
    Cmd_Color = 9'($urandom);
  endtask

  // Leaves the bench in the SETUP cycle of the accepted command.
  task automatic issue(input int x0, input int y0, input int x1, input int y1, input logic [8:0] col);
    int k = 0;
    while (!Cmd_Ready && k < 200) begin
      tick();
      k++;
    end
    chk("ready_wait", {127'b0, Cmd_Ready}, 128'd1);
    Cmd_X0 = x0; Cmd_Y0 = y0; Cmd_X1 = x1; Cmd_Y1 = y1; Cmd_Color = col;
    Cmd_Valid = 1'b1;
    cur_col = col;
    build_exp(x0, y0, x1, y1);
    tick();
    Cmd_Valid = 1'b0;
  endtask

  task automatic run_timeline(input bit hold, input int max_pix);
    logic [31:0] ecol;
    ecol = {23'b0, cur_col};
    chk("setup", {124'b0, flags()}, {124'b0, 4'b0001});
    if (!hold) noise();
    for (int i = 0; i < ex_q.size() && i < max_pix; i++) begin
      tick();
      chk("pixel", {Draw_X, Draw_Y, Draw_Color, 28'b0, flags()},
          {32'(ex_q[i]), 32'(ey_q[i]), ecol, 28'b0, 4'b1001});
      if (!hold) noise();
    end
    if (max_pix < ex_q.size()) return;
    if (!hold) Cmd_Valid = 1'b0;
    tick();
    chk("fin", {124'b0, flags()}, {124'b0, 4'b0110});
    if (!hold) begin
      Cmd_Valid = 1'b0;
      tick();
      chk("idle", {124'b0, flags()}, {124'b0, 4'b0010});
    end
  endtask

  initial begin
    Reset = 1'b1; Cmd_Valid = 1'b0;
    Cmd_X0 = 0; Cmd_Y0 = 0; Cmd_X1 = 0; Cmd_Y1 = 0; Cmd_Color = '0;
    cur_col = '0;
    tick(); tick();
    chk("reset", {Draw_X, Draw_Y, Draw_Color, 28'b0, flags()}, {96'b0, 28'b0, 4'b0010});
    Reset = 1'b0;
    tick();

    // Full-screen clear.
    issue(0, 0, 159, 119, 9'h1FF);
    chk("full_count", 128'(ex_q.size()), 128'd19200);
    run_timeline(1'b0, 1 << 30);

    // Swapped corners.
    issue(5, 3, 2, 4, 9'h0A5);
    chk("swap_count", 128'(ex_q.size()), 128'd8);
    run_timeline(1'b0, 1 << 30);

    // Negative corner, clipped to two pixels.
    issue(-10, -10, 1, 0, 9'h123);
    chk("neg_count", 128'(ex_q.size()), 128'd2);
    run_timeline(1'b0, 1 << 30);

    // Fully off-screen.
    issue(200, 50, 300, 60, 9'h0F0);
    chk("off_count", 128'(ex_q.size()), 128'd0);
    run_timeline(1'b0, 1 << 30);

    // Single pixel followed by a second command held valid through it.
    issue(159, 119, 159, 119, 9'h07E);
    Cmd_X0 = 10; Cmd_Y0 = 20; Cmd_X1 = 12; Cmd_Y1 = 21; Cmd_Color = 9'h155;
    Cmd_Valid = 1'b1;
    run_timeline(1'b1, 1 << 30);
    tick();
    Cmd_Valid = 1'b0;
    cur_col = 9'h155;
    build_exp(10, 20, 12, 21);
    run_timeline(1'b0, 1 << 30);

    // Reset after 10 writes of a full-screen fill, with a command present.
    issue(0, 0, 159, 119, 9'h1C7);
    run_timeline(1'b0, 10);
    Reset = 1'b1;
    Cmd_Valid = 1'b1; Cmd_X0 = 0; Cmd_Y0 = 0; Cmd_X1 = 3; Cmd_Y1 = 3;
    tick();
    chk("mid_reset", {Draw_X, Draw_Y, Draw_Color, 28'b0, flags()}, {96'b0, 28'b0, 4'b0010});
    Reset = 1'b0;
    Cmd_Valid = 1'b0;
    tick();
    chk("post_reset", {124'b0, flags()}, {124'b0, 4'b0010});
    issue(30, 40, 33, 41, 9'h00F);
    run_timeline(1'b0, 1 << 30);

    // Random small rectangles straddling the edges.
    for (int n = 0; n < 12; n++) begin
      int x0, y0, x1, y1;
      x0 = int'($urandom_range(0, 220)) - 30;
      y0 = int'($urandom_range(0, 170)) - 25;
      x1 = x0 + int'($urandom_range(0, 40)) - 20;
      y1 = y0 + int'($urandom_range(0, 30)) - 15;
      issue(x0, y0, x1, y1, 9'($urandom));
      run_timeline(1'b0, 1 << 30);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
